// File: rtl/avalon_multi_distance_interface.sv
`default_nettype none
// ============================================================================
// Module   : avalon_multi_distance_interface
// Purpose  : Round-robin multi-channel ultrasonic ranger behind an Avalon
//            register window (distance, status, threshold, car count).
// Revision : 1.0  initial release
// ============================================================================
module avalon_multi_distance_interface #(
    parameter int          NUM_CH         = 4,
    parameter logic [15:0] BASE_ADDR      = 16'h0900,
    parameter int          TRIG_CYCLES    = 500,
    parameter int          TIMEOUT_CYCLES = 1500000,
    parameter int          GAP_CYCLES     = 3000000,
    parameter int          CNT_W          = 24,
    parameter int          SHIFT          = 4,
    parameter logic [15:0] THRESH_DEFAULT = 16'h0100
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic [15:0]       address,
    input  logic              io_select,
    input  logic              write_en,
    input  logic [15:0]       write_data,
    input  logic [NUM_CH-1:0] echo,
    output logic [NUM_CH-1:0] trigger,
    output logic [15:0]       read_data,
    output logic              meas_done
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t            state_q;
    logic [CH_W-1:0]   cur_ch_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [NUM_CH-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_CH-1:0] trigger_q, ctrl_q, new_q, car_q, valid_q, tout_q;
    logic [15:0]       dist_q   [NUM_CH];
    logic [15:0]       thresh_q [NUM_CH];
    logic [15:0]       count_q  [NUM_CH];
    logic [15:0]       read_data_q;
    logic              meas_done_q;

    logic [CH_W-1:0]   nxt_ch_d;
    logic              nxt_ok_d;
    logic              echo_s_d, rise_d, rec_d, rec_to_d, car_d;
    logic [31:0]       shifted_d;
    logic [15:0]       res_dist_d;
    logic [15:0]       off_d, rdata_d;
    logic [CH_W-1:0]   a_ch_d;
    logic              in_ch_d, is_ctrl_d, is_new_d, rd_d, wr_d;

    // Next enabled channel strictly after the current pointer, wrapping.
    always_comb begin
        nxt_ok_d = 1'b0;
        nxt_ch_d = cur_ch_q;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!nxt_ok_d && ctrl_q[CH_W'((int'(cur_ch_q) + k) % NUM_CH)]) begin
                nxt_ok_d = 1'b1;
                nxt_ch_d = CH_W'((int'(cur_ch_q) + k) % NUM_CH);
            end
        end
    end

    assign echo_s_d   = sync2_q[cur_ch_q];
    assign rise_d     = sync2_q[cur_ch_q] & ~prev_q[cur_ch_q];
    assign shifted_d  = 32'(cnt_q) >> SHIFT;
    assign res_dist_d = rec_to_d ? 16'hFFFF :
                        (shifted_d > 32'h0000_FFFF) ? 16'hFFFF : shifted_d[15:0];
    assign car_d      = !rec_to_d && (res_dist_d < thresh_q[cur_ch_q]);

    always_comb begin
        rec_d    = 1'b0;
        rec_to_d = 1'b0;
        case (state_q)
            S_WAIT_RISE: if (!rise_d && cnt_q == TO_LAST) begin
                rec_d    = 1'b1;
                rec_to_d = 1'b1;
            end
            S_MEASURE: begin
                if (!echo_s_d) begin
                    rec_d = 1'b1;
                end else if (cnt_q == TO_LAST) begin
                    rec_d    = 1'b1;
                    rec_to_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign off_d     = address - BASE_ADDR;
    assign in_ch_d   = off_d < 16'(16 * NUM_CH);
    assign a_ch_d    = off_d[CH_W+3:4];
    assign is_ctrl_d = off_d == 16'h0100;
    assign is_new_d  = off_d == 16'h0104;
    assign rd_d      = io_select & ~write_en;
    assign wr_d      = io_select & write_en;

    always_comb begin
        rdata_d = '0;
        if (in_ch_d) begin
            case (off_d[3:0])
                4'h0:    rdata_d = dist_q[a_ch_d];
                4'h4:    rdata_d = {14'b0, tout_q[a_ch_d], valid_q[a_ch_d]};
                4'h8:    rdata_d = thresh_q[a_ch_d];
                4'hC:    rdata_d = count_q[a_ch_d];
                default: rdata_d = '0;
            endcase
        end else if (is_ctrl_d) begin
            rdata_d[NUM_CH-1:0] = ctrl_q;
        end else if (is_new_d) begin
            rdata_d[NUM_CH-1:0] = new_q;
        end
    end

    // Statement order matters: NEW read-clear precedes the record (set wins),
    // and the COUNT write-clear follows it (clear wins).
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q     <= S_IDLE;
            cur_ch_q    <= CH_W'(NUM_CH - 1);
            cnt_q       <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            trigger_q   <= '0;
            ctrl_q      <= '1;
            new_q       <= '0;
            car_q       <= '0;
            valid_q     <= '0;
            tout_q      <= '0;
            read_data_q <= '0;
            meas_done_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                dist_q[i]   <= '0;
                thresh_q[i] <= THRESH_DEFAULT;
                count_q[i]  <= '0;
            end
        end else begin
            sync1_q     <= echo;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            meas_done_q <= 1'b0;

            if (rd_d) begin
                read_data_q <= rdata_d;
                if (is_new_d) new_q <= '0;
            end

            case (state_q)
                S_IDLE: if (nxt_ok_d) begin
                    cur_ch_q  <= nxt_ch_d;
                    trigger_q <= NUM_CH'(1) << nxt_ch_d;
                    cnt_q     <= '0;
                    state_q   <= S_TRIG;
                end
                S_TRIG: begin
                    if (cnt_q == TRIG_LAST) begin
                        trigger_q <= '0;
                        cnt_q     <= '0;
                        state_q   <= S_WAIT_RISE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_RISE: begin
                    if (rise_d) begin
                        cnt_q   <= '0;
                        state_q <= S_MEASURE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_MEASURE: cnt_q <= cnt_q + CNT_W'(1);
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (rec_d) begin
                dist_q[cur_ch_q]  <= res_dist_d;
                valid_q[cur_ch_q] <= 1'b1;
                tout_q[cur_ch_q]  <= rec_to_d;
                new_q[cur_ch_q]   <= 1'b1;
                car_q[cur_ch_q]   <= car_d;
                meas_done_q       <= 1'b1;
                if (car_d && !car_q[cur_ch_q] && count_q[cur_ch_q] != 16'hFFFF)
                    count_q[cur_ch_q] <= count_q[cur_ch_q] + 16'd1;
                cnt_q   <= '0;
                state_q <= S_GAP;
            end

            if (wr_d) begin
                if (in_ch_d && off_d[3:0] == 4'h8) thresh_q[a_ch_d] <= write_data;
                if (in_ch_d && off_d[3:0] == 4'hC) count_q[a_ch_d]  <= '0;
                if (is_ctrl_d) ctrl_q <= write_data[NUM_CH-1:0];
            end
        end
    end

    assign trigger   = trigger_q;
    assign read_data = read_data_q;
    assign meas_done = meas_done_q;

endmodule
`default_nettype wire

// File: tb/tb_avalon_multi_distance_interface.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_multi_distance_interface
// Purpose  : Self-checking bench: register table, scenario sequences and a
//            randomized echo/car-count reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_avalon_multi_distance_interface;
    localparam int          NUM_CH = 4;
    localparam logic [15:0] BASE   = 16'h0900;
    localparam logic [15:0] A_CTRL = BASE + 16'h0100;
    localparam logic [15:0] A_NEW  = BASE + 16'h0104;

    logic              clk = 1'b0;
    logic              reset_l;
    logic [15:0]       address;
    logic              io_select;
    logic              write_en;
    logic [15:0]       write_data;
    logic [NUM_CH-1:0] echo;
    logic [NUM_CH-1:0] trigger;
    logic [15:0]       read_data;
    logic              meas_done;

    int total = 0;
    int bad   = 0;
    int md_seen;
    int w_ch[8], w_len[8], w_got, w_ovl;
    logic [15:0] rd;

    always #5 clk = ~clk;

    avalon_multi_distance_interface #(
        .NUM_CH(NUM_CH), .BASE_ADDR(BASE), .TRIG_CYCLES(4), .TIMEOUT_CYCLES(200),
        .GAP_CYCLES(8), .CNT_W(24), .SHIFT(0), .THRESH_DEFAULT(16'h0100)
    ) dut (
        .clk(clk), .reset_l(reset_l), .address(address), .io_select(io_select),
        .write_en(write_en), .write_data(write_data), .echo(echo),
        .trigger(trigger), .read_data(read_data), .meas_done(meas_done)
    );

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
        string       name;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t mk(bit wr, logic [15:0] a, logic [15:0] d, logic [15:0] e, string n);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.exp = e; v.name = n;
        return v;
    endfunction

    function automatic logic [15:0] reg_a(input int ch, input int r);
        return BASE + 16'(16 * ch + r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp);
        total++;
        if (act < exp - 1 || act > exp + 1) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d +/-1", name, act, exp);
        end
    endtask

    // Bus helpers are entered at a negedge and return at the next negedge.
    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        address = a; write_data = d; write_en = 1'b1; io_select = 1'b1;
        @(negedge clk);
        io_select = 1'b0; write_en = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        address = a; write_en = 1'b0; io_select = 1'b1;
        @(negedge clk);
        io_select = 1'b0;
        d = read_data;
    endtask

    task automatic do_reset();
        reset_l = 1'b0; io_select = 1'b0; write_en = 1'b0; echo = '0;
        repeat (2) @(negedge clk);
        reset_l = 1'b1;
    endtask

    task automatic wait_trig_fall(input int ch, output bit ok);
        int n = 0;
        while (!trigger[ch] && n < 3000) begin @(negedge clk); n++; end
        while (trigger[ch] && n < 3000) begin @(negedge clk); n++; end
        ok = (n < 3000);
    endtask

    // Waits for channel ch to finish triggering, then returns an echo of
    // 'width' cycles (0 = no echo) after 'dly' cycles; ends at meas_done.
    task automatic shoot(input int ch, input int dly, input int width);
        bit ok;
        int n = 0;
        md_seen = 0;
        wait_trig_fall(ch, ok);
        check("trigger_fall_seen", 32'(ok), 1);
        repeat (dly) begin @(negedge clk); md_seen += int'(meas_done); end
        if (width > 0) begin
            echo[ch] = 1'b1;
            repeat (width) begin @(negedge clk); md_seen += int'(meas_done); end
            echo[ch] = 1'b0;
        end
        while (!meas_done && n < 400) begin @(negedge clk); n++; end
        if (meas_done) md_seen++;
        check("meas_done_seen", 32'(meas_done), 1);
    endtask

    // Records channel and high-length of the next n trigger pulses.
    task automatic watch_triggers(input int n, input int budget);
        int cyc = 0, cur = -1, len = 0, idx;
        w_got = 0; w_ovl = 0;
        while (w_got < n && cyc < budget) begin
            @(negedge clk); cyc++;
            if ($countones(trigger) > 1) w_ovl++;
            if (trigger != '0) begin
                idx = 0;
                for (int b = 0; b < NUM_CH; b++) if (trigger[b]) idx = b;
                if (cur < 0) begin cur = idx; len = 0; end
                len++;
            end else if (cur >= 0) begin
                w_ch[w_got] = cur; w_len[w_got] = len; w_got++; cur = -1;
            end
        end
    endtask

    int exp_rr[5] = '{0, 1, 2, 3, 0};
    int th_m[NUM_CH], car_m[NUM_CH], cnt_m[NUM_CH];

    initial begin
        int w, dly, n, nz;
        logic [15:0] seen;
        address = '0; write_data = '0; io_select = 1'b0; write_en = 1'b0; echo = '0;
        reset_l = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_trigger", 32'(trigger), 0);
        check("rst_read_data", 32'(read_data), 0);
        check("rst_meas_done", 32'(meas_done), 0);
        reset_l = 1'b1;

        // ---- register table right after reset ----
        vt.push_back(mk(0, reg_a(0, 0), 0, 16'h0000, "dist0_rst"));
        vt.push_back(mk(0, reg_a(0, 4), 0, 16'h0000, "status0_rst"));
        vt.push_back(mk(0, reg_a(1, 12), 0, 16'h0000, "count1_rst"));
        vt.push_back(mk(0, A_NEW, 0, 16'h0000, "new_rst"));
        vt.push_back(mk(0, reg_a(0, 8), 0, 16'h0100, "thresh0_rst"));
        vt.push_back(mk(0, reg_a(3, 8), 0, 16'h0100, "thresh3_rst"));
        vt.push_back(mk(0, A_CTRL, 0, 16'h000F, "ctrl_rst"));
        vt.push_back(mk(0, BASE + 16'h0200, 0, 16'h0000, "unmapped_200"));
        vt.push_back(mk(0, BASE + 16'h0002, 0, 16'h0000, "unmapped_002"));
        vt.push_back(mk(1, reg_a(0, 0), 16'h1234, 0, "wr_dist0"));
        vt.push_back(mk(0, reg_a(0, 0), 0, 16'h0000, "dist0_ro"));
        vt.push_back(mk(1, reg_a(1, 8), 16'h0ABC, 0, "wr_thresh1"));
        vt.push_back(mk(0, reg_a(1, 8), 0, 16'h0ABC, "thresh1_rw"));
        vt.push_back(mk(1, A_CTRL, 16'h00F5, 0, "wr_ctrl"));
        vt.push_back(mk(0, A_CTRL, 0, 16'h0005, "ctrl_masked"));
        vt.push_back(mk(1, A_CTRL, 16'h000F, 0, "wr_ctrl_back"));
        vt.push_back(mk(1, A_NEW, 16'hFFFF, 0, "wr_new"));
        vt.push_back(mk(0, A_NEW, 0, 16'h0000, "new_ro"));
        @(negedge clk);
        foreach (vt[i]) begin
            if (vt[i].wr) bus_write(vt[i].addr, vt[i].data);
            else begin
                bus_read(vt[i].addr, rd);
                check(vt[i].name, 32'(rd), 32'(vt[i].exp));
            end
        end

        // ---- round-robin order, all echoes low ----
        do_reset();
        watch_triggers(5, 5000);
        check("rr_pulses", 32'(w_got), 5);
        check("rr_overlap", 32'(w_ovl), 0);
        for (int i = 0; i < 5; i++) begin
            check("rr_channel", 32'(w_ch[i]), 32'(exp_rr[i]));
            check("rr_width", 32'(w_len[i]), 4);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            bus_read(reg_a(c, 4), rd); check("rr_status", 32'(rd), 3);
            bus_read(reg_a(c, 0), rd); check("rr_dist", 32'(rd), 16'hFFFF);
        end

        // ---- single echo on channel 1 ----
        bus_write(A_CTRL, 16'h0002);
        n = 0;
        while (!trigger[1] && n < 3000) begin @(negedge clk); n++; end
        check("ch1_trigger_rise", 32'(trigger[1]), 1);
        bus_read(A_NEW, rd);
        shoot(1, 10, 50);
        check("ch1_meas_done_once", 32'(md_seen), 1);
        bus_read(reg_a(1, 0), rd); check_near("ch1_dist", int'(rd), 50);
        bus_read(reg_a(1, 4), rd); check("ch1_status", 32'(rd), 1);
        bus_read(A_NEW, rd); check("ch1_new", 32'(rd), 2);
        bus_read(A_NEW, rd); check("ch1_new_cleared", 32'(rd), 0);

        // ---- car counting on channel 2 ----
        bus_write(A_CTRL, 16'h0004);
        bus_write(reg_a(2, 8), 16'd40);
        shoot(2, 5, 30);
        shoot(2, 5, 30);
        shoot(2, 5, 60);
        bus_read(reg_a(2, 0), rd); check_near("ch2_dist_far", int'(rd), 60);
        shoot(2, 5, 30);
        bus_read(reg_a(2, 12), rd); check("ch2_count", 32'(rd), 2);
        bus_write(reg_a(2, 12), 16'h0007);
        bus_read(reg_a(2, 12), rd); check("ch2_count_clr", 32'(rd), 0);

        // ---- randomized echoes against the reference model ----
        do_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            th_m[c] = $urandom_range(20, 120); car_m[c] = 0; cnt_m[c] = 0;
            bus_write(reg_a(c, 8), 16'(th_m[c]));
        end
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                w = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(5, 150);
                if (w > 0 && w + 2 >= th_m[c] && w <= th_m[c] + 2) w = th_m[c] + 5;
                dly = $urandom_range(2, 15);
                shoot(c, dly, w);
                bus_read(reg_a(c, 0), rd);
                if (w == 0) check("rnd_dist_timeout", 32'(rd), 16'hFFFF);
                else        check_near("rnd_dist", int'(rd), w);
                bus_read(reg_a(c, 4), rd);
                check("rnd_status", 32'(rd), (w == 0) ? 3 : 1);
                if (w > 0 && w < th_m[c]) begin
                    if (car_m[c] == 0 && cnt_m[c] < 16'hFFFF) cnt_m[c]++;
                    car_m[c] = 1;
                end else begin
                    car_m[c] = 0;
                end
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            bus_read(reg_a(c, 12), rd); check("rnd_count", 32'(rd), 32'(cnt_m[c]));
        end

        // ---- enable mask ----
        bus_write(A_CTRL, 16'h0005);
        repeat (300) @(negedge clk);
        watch_triggers(4, 3000);
        check("mask_pulses", 32'(w_got), 4);
        for (int i = 0; i < 4; i++) begin
            check("mask_ch_allowed", 32'(w_ch[i] == 0 || w_ch[i] == 2), 1);
            if (i > 0) check("mask_alternate", 32'(w_ch[i] != w_ch[i-1]), 1);
        end
        bus_write(A_CTRL, 16'h0000);
        repeat (400) @(negedge clk);
        nz = 0;
        repeat (300) begin @(negedge clk); if (trigger != '0) nz++; end
        check("mask_zero_quiet", 32'(nz), 0);

        // ---- reset during MEASURE on channel 3 ----
        bus_write(A_CTRL, 16'h0008);
        begin
            bit ok;
            wait_trig_fall(3, ok);
            check("ch3_trigger_fall", 32'(ok), 1);
        end
        repeat (5) @(negedge clk);
        echo[3] = 1'b1;
        repeat (10) @(negedge clk);
        bus_read(reg_a(0, 8), rd);
        check("thresh0_random", 32'(rd), 32'(th_m[0]));
        reset_l = 1'b0;
        @(negedge clk);
        check("midrst_trigger", 32'(trigger), 0);
        check("midrst_read_data", 32'(read_data), 0);
        reset_l = 1'b1; echo = '0;
        n = 0;
        while (trigger == '0 && n < 50) begin @(negedge clk); n++; end
        check("midrst_first_ch", 32'(trigger), 32'h1);
        bus_read(reg_a(0, 8), rd); check("midrst_thresh0", 32'(rd), 16'h0100);

        // ---- NEW read colliding with its own set ----
        address = A_NEW; write_en = 1'b0; io_select = 1'b1;
        seen = '0; n = 0;
        while (!meas_done && n < 600) begin @(negedge clk); seen |= read_data; n++; end
        io_select = 1'b0;
        check("race_meas_done", 32'(meas_done), 1);
        bus_read(A_NEW, rd); check("race_new_kept", 32'(rd), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
